// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply is a shift-add over operand magnitudes and divide is a restoring
// subtract, one bit per cycle. Signs are reapplied in FIXUP. Divide-by-zero
// and signed overflow finish directly from IDLE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   prod_q, prod_d;    // {acc/remainder, multiplier/quotient}
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept time
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = op[2];
    assign a_sgn    = is_div ? ~op[0] : (op[1:0] != 2'b11);
    assign b_sgn    = is_div ? ~op[0] : ~op[1];
    assign a_neg    = a_sgn & operand_A[XLEN-1];
    assign b_neg    = b_sgn & operand_B[XLEN-1];
    assign a_mag    = a_neg ? -operand_A : operand_A;
    assign b_mag    = b_neg ? -operand_B : operand_B;
    assign div_zero = is_div & (operand_B == '0);
    assign div_ovf  = is_div & ~op[0] & (operand_A == {1'b1, {(XLEN-1){1'b0}}})
                      & (operand_B == '1);

    // One iteration step for each operation class
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[XLEN];

    // Sign correction of the finished magnitudes
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quot_fix = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2])               fix_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
        else                       fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d = op;
                    if (div_zero) begin
                        result_d = op[1] ? operand_A : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : operand_A;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        if (is_div) begin
                            prod_d = {{XLEN{1'b0}}, a_mag};
                            opb_d  = b_mag;
                            // remainder follows the dividend, quotient the xor
                            neg_d  = op[1] ? a_neg : (a_neg ^ b_neg);
                        end else begin
                            prod_d = {{XLEN{1'b0}}, b_mag};
                            opb_d  = a_mag;
                            neg_d  = a_neg ^ b_neg;
                        end
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2])
                        prod_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                                  prod_q[XLEN-2:0], div_ge};
                    else
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_A = '0;
    logic [31:0] operand_B = '0;
    logic        flush = 1'b0;
    logic        ready, done;
    logic [31:0] result;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                           DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_A(operand_A), .operand_B(operand_B), .flush(flush),
        .ready(ready), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, measure negedges from accept until done, check result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input bit disturb);
        int n;
        bit seen;
        @(negedge clock);
        start = 1'b1; op = o; operand_A = a; operand_B = b;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clock);
            n++;
            if (disturb && n == 5) begin
                start = 1'b1; op = DIVU; operand_A = 32'd100; operand_B = 32'd7;
            end
            if (disturb && n == 6) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".res"}, result, exp_res);
        @(negedge clock);
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
    endtask

    // Count done pulses over a window
    task automatic watch_no_done(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (done) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int n, first, second;
        #3 reset = 1'b1;
        #2;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_op("mul4x5",   MUL,    32'd4,        32'd5,        34, 32'd20,       1'b0);
        run_op("mulhu",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 1'b0);
        run_op("mulh",     MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000000, 1'b0);
        run_op("mulhsu",   MULHSU, 32'hFFFFFFFF, 32'd2,        34, 32'hFFFFFFFF, 1'b0);
        run_op("mul_big",  MUL,    32'h12345678, 32'h10,       34, 32'h23456780, 1'b0);
        run_op("div",      DIV,    32'hFFFFFFF6, 32'd3,        34, 32'hFFFFFFFD, 1'b0);
        run_op("rem",      REM,    32'hFFFFFFF6, 32'd3,        34, 32'hFFFFFFFF, 1'b0);
        run_op("divu",     DIVU,   32'd10,       32'd3,        34, 32'd3,        1'b0);
        run_op("divu_big", DIVU,   32'hFFFFFFFF, 32'h10,       34, 32'h0FFFFFFF, 1'b0);
        run_op("div_nb",   DIV,    32'd7,        32'hFFFFFFFE, 34, 32'hFFFFFFFD, 1'b0);
        run_op("rem_nb",   REM,    32'd7,        32'hFFFFFFFE, 34, 32'd1,        1'b0);
        run_op("divu_z",   DIVU,   32'd7,        32'd0,        1,  32'hFFFFFFFF, 1'b0);
        run_op("remu_z",   REMU,   32'd7,        32'd0,        1,  32'd7,        1'b0);
        run_op("rem_ovf",  REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'd0,        1'b0);
        run_op("div_ovf",  DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, 1'b0);
        run_op("ignore",   MUL,    32'd4,        32'd5,        34, 32'd20,       1'b1);

        // flush together with start in IDLE: no accept
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = MUL; operand_A = 32'd3; operand_B = 32'd3;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle.ready", 32'(ready), 32'd1);
        watch_no_done("flush_idle.nodone", 40);
        chk("flush_idle.result", result, 32'd20);

        // flush mid-calculation
        @(negedge clock);
        start = 1'b1; op = MUL; operand_A = 32'd3; operand_B = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        chk("flush.busy", 32'(ready), 32'd0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush.ready", 32'(ready), 32'd1);
        chk("flush.result", result, 32'd20);
        watch_no_done("flush.nodone", 40);
        chk("flush.result2", result, 32'd20);

        // reset mid-calculation
        @(negedge clock);
        start = 1'b1; op = DIVU; operand_A = 32'd100; operand_B = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_mid.result", result, 32'd0);
        chk("rst_mid.ready", 32'(ready), 32'd1);
        chk("rst_mid.done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watch_no_done("rst_mid.nodone", 40);

        // first op after reset
        run_op("post_rst", DIVU, 32'd100, 32'd7, 34, 32'd14, 1'b0);

        // back-to-back with start held high
        @(negedge clock);
        start = 1'b1; op = MUL; operand_A = 32'd4; operand_B = 32'd5;
        @(posedge clock);
        n = 0; first = 0; second = 0;
        while (n < 120 && second == 0) begin
            @(negedge clock);
            n++;
            if (n == 1) begin op = DIVU; operand_A = 32'd10; operand_B = 32'd3; end
            if (n == 36) start = 1'b0;
            if (done) begin
                if (first == 0) begin
                    first = n;
                    chk("b2b.res1", result, 32'd20);
                end else begin
                    second = n;
                    chk("b2b.res2", result, 32'd3);
                end
            end
        end
        start = 1'b0;
        chk("b2b.lat1", 32'(first), 32'd34);
        chk("b2b.lat2", 32'(second), 32'd69);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand/result width; legal values are even integers >= 4.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 start  input  1  SHALL request a new operation; it is sampled only when ready=1.
REQ-005 op  input  3  SHALL select the RV32M funct3 operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_A  input  XLEN  SHALL be the multiplicand or dividend.
REQ-007 operand_B  input  XLEN  SHALL be the multiplier or divisor.
REQ-008 flush  input  1  SHALL abort any in-flight operation.
REQ-009 ready  output  1  SHALL be high only in IDLE.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-011 result  output  XLEN  SHALL hold the last completed result.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, CALC, FIXUP and DONE.
REQ-013 Accept: on an edge with state=IDLE and start=1, op and operands SHALL be latched; later input changes SHALL have no effect on that operation.
REQ-014 From IDLE, a normal accept SHALL move to CALC with iteration counter=0.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle on operand magnitudes.
REQ-016 CALC SHALL go to FIXUP after exactly XLEN iterations.
REQ-017 FIXUP SHALL apply sign correction, register result and go to DONE.
REQ-018 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-019 Normal latency SHALL be XLEN+2 cycles: done is high in the cycle following edge E0+XLEN+1, where E0 is the accept edge.
REQ-020 Multiply SHALL form the 2*XLEN product: MUL returns the low half; MULH, MULHSU and MULHU return the high half with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-021 DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-022 Fast path, divide by zero (operand_B=0): the FSM SHALL go IDLE->DONE at E0. DIV/DIVU return all ones; REM/REMU return operand_A.
REQ-023 Fast path, signed overflow (DIV/REM with A = -2^(XLEN-1), B = -1): the FSM SHALL go IDLE->DONE at E0. DIV returns A; REM returns 0.
REQ-024 Fast-path latency SHALL be 1 cycle: done is high in the cycle after E0.
REQ-025 start while ready=0 SHALL be ignored; it is not queued.
REQ-026 flush=1 on any edge in CALC, FIXUP or DONE SHALL force IDLE and suppress done; result keeps its prior value.
REQ-027 flush=1 together with start in IDLE SHALL take priority: no accept occurs.
REQ-028 result SHALL change only on the edge entering DONE and SHALL hold until the next completion.
REQ-029 There SHALL be no combinational path from any input to ready, done or result.

Reset
REQ-030 Asserting reset SHALL immediately force: state=IDLE, ready=1, done=0, result=0, counter=0, internal registers 0.
REQ-031 Reset asserted mid-operation SHALL discard that operation; no done follows deassertion.
REQ-032 After reset deasserts, the first accept SHALL behave per REQ-013.

Verification (XLEN=32)
REQ-033 MUL A=4, B=5 -> done exactly 34 cycles after accept, result=20; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH A=B=0xFFFFFFFF -> 0.
REQ-034 DIV A=-10, B=3 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU A=10, B=3 -> 3.
REQ-035 DIVU A=7, B=0 -> 0xFFFFFFFF with done 1 cycle after accept; REM A=0x80000000, B=0xFFFFFFFF -> 0 in 1 cycle.
REQ-036 Change operands and pulse start during CALC -> ignored; result still matches the originally latched operands.
REQ-037 flush at iteration 10 -> ready=1 next cycle, no done, result unchanged; reset at iteration 10 -> result=0 immediately, no done.
REQ-038 Back-to-back ops with start held high -> second accept occurs in the first IDLE cycle after DONE, and its done arrives 34 cycles later.
